// File: rtl/sc_stream_decoder_if.sv
// Bundle of the stream decoder's control, sample and result signals.
//
// Signalling: start is a request that the decoder accepts on any rising edge
// where it is idle (busy low); there is no ready/acknowledge, and a start seen
// while busy is dropped. bit_vld qualifies bit_in on every edge, and only
// qualified samples are counted. done is a single-cycle strobe that marks
// result as freshly updated; result then holds until the next completed window.
interface sc_stream_decoder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] len;
   logic             abort;
   logic             bit_vld;
   logic             bit_in;
   logic             busy;
   logic             done;
   logic [WIDTH:0]   result;
   logic             dbg_state;

   modport master (
      output start, len, abort, bit_vld, bit_in,
      input  busy, done, result, dbg_state
   );

   modport slave (
      input  start, len, abort, bit_vld, bit_in,
      output busy, done, result, dbg_state
   );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts the ones of a qualified serial
// bitstream over a programmable window and reports the count with a
// one-cycle done strobe. A window length of 0 selects 2^WIDTH samples.
module sc_stream_decoder #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   sc_stream_decoder_if.slave bus
);
   localparam logic [0:0]     IDLE  = 1'b0;
   localparam logic [0:0]     COUNT = 1'b1;
   localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};
   localparam logic [WIDTH:0] FULL  = {1'b1, {WIDTH{1'b0}}};

   logic [0:0]     state;
   logic [WIDTH:0] acc;
   logic [WIDTH:0] remaining;
   logic [WIDTH:0] acc_next;
   logic [WIDTH:0] load_len;

   // Count including the current sample; acc never exceeds the window size.
   assign acc_next = acc + {{WIDTH{1'b0}}, bus.bit_in};
   // A zero length encodes the full 2^WIDTH window.
   assign load_len = (bus.len == '0) ? FULL : {1'b0, bus.len};
   // Current FSM state exposed for observation.
   assign bus.dbg_state = state;

   // Window FSM: accept start in IDLE, count qualified samples in COUNT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         acc        <= '0;
         remaining  <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
      end else begin
         bus.done <= 1'b0;
         if (state == IDLE) begin
            // The start cycle never samples bit_in; abort has no meaning here.
            if (bus.start) begin
               remaining <= load_len;
               acc       <= '0;
               state     <= COUNT;
               bus.busy  <= 1'b1;
            end
         end else begin
            if (bus.abort) begin
               // Drop the partial count; result keeps the last completed window.
               state    <= IDLE;
               bus.busy <= 1'b0;
               acc      <= '0;
            end else if (bus.bit_vld) begin
               if (remaining > ONE) begin
                  acc       <= acc_next;
                  remaining <= remaining - ONE;
               end else begin
                  // Last sample of the window.
                  bus.result <= acc_next;
                  bus.done   <= 1'b1;
                  bus.busy   <= 1'b0;
                  state      <= IDLE;
                  remaining  <= '0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: directed windows checked every cycle against a
// queue-based window model, plus hand-computed literal expectations.
module tb_sc_stream_decoder;
   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;

   sc_stream_decoder_if #(.WIDTH(WIDTH)) bus ();

   sc_stream_decoder #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model state: window open flag, its length and the qualified samples so far.
   logic           m_active = 1'b0;
   int             m_len = 0;
   int             m_samp[$];
   int             m_result = 0;
   logic           m_done = 1'b0;
   logic [WIDTH:0] exp_q[$];
   int             m_sum;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Window model: a window closes when it has collected its length of samples.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 1'b0;
         m_samp.delete();
         m_result = 0;
         m_done   = 1'b0;
      end else begin
         m_done = 1'b0;
         if (!m_active) begin
            if (bus.start === 1'b1) begin
               m_active = 1'b1;
               m_len    = (bus.len == 0) ? (1 << WIDTH) : int'(bus.len);
               m_samp.delete();
            end
         end else if (bus.abort === 1'b1) begin
            m_active = 1'b0;
            m_samp.delete();
         end else if (bus.bit_vld === 1'b1) begin
            m_samp.push_back(int'(bus.bit_in));
            if (m_samp.size() == m_len) begin
               m_sum = 0;
               foreach (m_samp[i]) m_sum += m_samp[i];
               m_result = m_sum;
               m_done   = 1'b1;
               m_active = 1'b0;
               exp_q.push_back(m_sum[WIDTH:0]);
            end
         end
      end
   end

   // Compare process: outputs against the model, completed results against the scoreboard.
   always @(negedge clk) begin
      check("busy", 32'(bus.busy), 32'(m_active));
      check("done", 32'(bus.done), 32'(m_done));
      check("result", 32'(bus.result), 32'(m_result));
      if (bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_pop actual=done_pulse expected=no_pending_window at %0t", $time);
         end else begin
            check("sb_result", 32'(bus.result), 32'(exp_q.pop_front()));
         end
      end
   end

   // Driver tasks
   task automatic drive(input logic s, input logic [WIDTH-1:0] l, input logic a,
                        input logic v, input logic b);
      @(negedge clk);
      bus.start   = s;
      bus.len     = l;
      bus.abort   = a;
      bus.bit_vld = v;
      bus.bit_in  = b;
   endtask

   task automatic settle();
      @(negedge clk);
      bus.start   = 1'b0;
      bus.len     = '0;
      bus.abort   = 1'b0;
      bus.bit_vld = 1'b0;
      bus.bit_in  = 1'b0;
      #1;
   endtask

   task automatic send_bits8(input logic [7:0] bits);
      for (int i = 7; i >= 0; i--) drive(1'b0, '0, 1'b0, 1'b1, bits[i]);
   endtask

   logic [6:0] vld_pat;

   initial begin
      bus.start   = 1'b0;
      bus.len     = '0;
      bus.abort   = 1'b0;
      bus.bit_vld = 1'b0;
      bus.bit_in  = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_result", 32'(bus.result), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Window of 8: bits 1,0,1,1,0,0,1,1 -> 5
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      #1;
      check("t1_busy_after_start", 32'(bus.busy), 1);
      for (int i = 6; i >= 0; i--) drive(1'b0, '0, 1'b0, 1'b1, logic'(8'b10110011 >> i));
      settle();
      check("t1_done", 32'(bus.done), 1);
      check("t1_busy", 32'(bus.busy), 0);
      check("t1_result", 32'(bus.result), 5);
      settle();
      check("t1_done_single", 32'(bus.done), 0);

      // Full window: len=0 -> 256 ones
      drive(1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      repeat (256) drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      settle();
      check("t2_done", 32'(bus.done), 1);
      check("t2_result", 32'(bus.result), 256);

      // Qualified samples only: vld 1,0,1,0,0,1,1 with bit_in=1
      vld_pat = 7'b1010011;
      drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 6; i >= 0; i--) drive(1'b0, '0, 1'b0, vld_pat[i], 1'b1);
      settle();
      check("t3a_done", 32'(bus.done), 1);
      check("t3a_result", 32'(bus.result), 4);
      // Ones only on unqualified cycles -> 0
      drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 6; i >= 0; i--) drive(1'b0, '0, 1'b0, vld_pat[i], ~vld_pat[i]);
      settle();
      check("t3b_done", 32'(bus.done), 1);
      check("t3b_result", 32'(bus.result), 0);

      // Result 5, then abort a window after 3 samples and a stray start
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      send_bits8(8'b10110011);
      settle();
      check("t4_pre_result", 32'(bus.result), 5);
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      repeat (3) drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b1);
      settle();
      check("t4_abort_busy", 32'(bus.busy), 0);
      check("t4_abort_done", 32'(bus.done), 0);
      check("t4_abort_result", 32'(bus.result), 5);
      // Stray start mid-window does not change the window length of 3
      drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 8'd1, 1'b0, 1'b1, 1'b1);
      #1;
      check("t4_stray_busy", 32'(bus.busy), 1);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      #1;
      check("t4_stray_no_early_done", 32'(bus.done), 0);
      settle();
      check("t4_len3_done", 32'(bus.done), 1);
      check("t4_len3_result", 32'(bus.result), 2);

      // Back-to-back: start during the done cycle
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      send_bits8(8'b10110011);
      drive(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
      #1;
      check("t5_first_done", 32'(bus.done), 1);
      check("t5_first_result", 32'(bus.result), 5);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      #1;
      check("t5_accepted_busy", 32'(bus.busy), 1);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      settle();
      check("t5_second_done", 32'(bus.done), 1);
      check("t5_second_result", 32'(bus.result), 2);

      // Asynchronous reset mid-window
      drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0);
      repeat (4) drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_busy", 32'(bus.busy), 0);
      check("t6_rst_done", 32'(bus.done), 0);
      check("t6_rst_result", 32'(bus.result), 0);
      check("t6_rst_state", 32'(bus.dbg_state), 0);
      settle();
      rst_n = 1'b1;
      drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      settle();
      check("t6_fresh_done", 32'(bus.done), 1);
      check("t6_fresh_result", 32'(bus.result), 2);

      repeat (3) settle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain actual=%0d pending expected=0 pending", exp_q.size());
      end

      // Final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary decoder for the counter-based SC MAC datapath; the receive end of the unary/stochastic bitstream that down-counter-driven generators emit.
- Counts the ones in a serial bitstream over a programmable window of sample cycles.
- Each bit is qualified by an enable.
- Returns the binary count with a one-cycle done pulse.

Parameters:
WIDTH, 8, binary width of window length; result is WIDTH+1 bits so a full 2^WIDTH window of ones is representable.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  begin a window; sampled only in IDLE.
len  input  WIDTH  window length in qualified samples, latched on accepted start; 0 means 2^WIDTH.
abort  input  1  cancel the current window; meaningful only in COUNT.
bit_vld  input  1  sample enable; bit_in is counted only when high.
bit_in  input  1  stochastic bitstream input.
busy  output  1  high while in COUNT.
done  output  1  one-cycle pulse when a window completes.
result  output  WIDTH+1  count of ones in the last completed window.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, result=0, internal acc=0, remaining=0.
- Registers: acc (WIDTH+1, up-counter of ones); remaining (WIDTH+1, down-counter of samples left).
- All outputs are registered.
- IDLE, start=1:
  - remaining <= (len==0) ? 2^WIDTH : len; acc <= 0; state <= COUNT; busy <= 1.
  - bit_in is not sampled on the start cycle. abort is ignored in IDLE.
- COUNT, priority order per cycle:
  1. abort=1: state <= IDLE, busy <= 0, acc <= 0. No done pulse, result unchanged, the in-flight sample is discarded.
  2. bit_vld=1 and remaining>1: acc <= acc + bit_in; remaining <= remaining - 1.
  3. bit_vld=1 and remaining==1 (last sample): result <= acc + bit_in, done <= 1, busy <= 0, state <= IDLE, remaining <= 0.
  4. bit_vld=0: hold acc and remaining; the bit is ignored.
- start while busy: ignored.
- done: high exactly one cycle after the final-sample edge, otherwise 0.
- Back-to-back windows: the done cycle is an IDLE cycle, so a start asserted during done is accepted.
- result: holds its value until the next completed window. Never updated by abort or start.
- Latency: with bit_vld held high and len=L (L>=1), start is sampled at edge 0, samples are taken at edges 1..L, and done/result are visible after edge L.
- Arithmetic: acc never exceeds remaining-initial (at most 2^WIDTH), so there is no overflow or wrap. Saturation logic is not required.
- Reset asserted mid-window: immediate return to reset values; the partial count is lost.

Test Plan:
- Reset, then start with len=8, bit_vld=1, bits 1,0,1,1,0,0,1,1 -> busy=1 for 8 cycles; done pulse one cycle after the 8th sample; result=5; busy=0 with done.
- len=0 (WIDTH=8), bit_in=1 constant, bit_vld=1 -> 256 samples, then result=256 (9'h100), a single done pulse.
- len=4, bit_vld=1,0,1,0,0,1,1 with bit_in=1 on all cycles -> only the 4 qualified ones count; result=4; done after the 7th stimulus cycle. Repeat with bit_in=1 only on vld=0 cycles -> result=0.
- Complete a window with result=5, then start len=8 and abort after 3 samples -> busy drops next cycle, no done, result stays 5. A start pulse during COUNT is ignored (window length unchanged).
- Complete a window with result=5, assert start with len=2 in the same cycle done is high -> new window accepted. Bits 1,1 -> result=2 with a second done pulse 3 cycles later.
- Start len=8, drive 4 ones, pull rst low asynchronously mid-cycle -> busy, done, result go to 0 immediately. After release, the bench issues a fresh start before any sampling occurs.
